// File: rtl/enemy_fire_scheduler.sv
// enemy_fire_scheduler
//   Chooses which living enemy fires next and which free bullet slot carries
//   the shot. After every shot (and after reset) a cooldown runs, then a
//   random candidate from a 16-bit Galois LFSR is tried. The shot is offered to
//   the bullet unit through a valid/ready handshake.
//
//   Optional feature macro: ENEMY_FIRE_SCAN_EN
//     defined   : a dead candidate starts a circular scan for the next alive
//                 enemy (one index per cycle, at most N_ENEMIES indices).
//     undefined : a dead candidate is simply retried next cycle with a fresh
//                 LFSR value.
//
// Ports
//   clk          system clock
//   reset        synchronous active-low reset
//   enable       game running; low pauses the cooldown and aborts a pick/scan
//   enemy_vivos  alive mask, bit i = enemy i alive
//   slot_busy    bullet slot in-flight mask
//   fire_ready   bullet unit accepts the shot
//   fire_valid   shot request pending (held until accepted)
//   fire_id      shooting enemy index
//   fire_slot    bullet slot to launch in
//   shot_count   accepted shots since reset, saturating at 255
module enemy_fire_scheduler #(
    parameter int          N_ENEMIES = 24,
    parameter int          N_SLOTS   = 3,
    parameter int          COOLDOWN  = 1000000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         ID_W      = $clog2(N_ENEMIES),
    localparam int         SLOT_W    = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N_ENEMIES-1:0] enemy_vivos,
    input  logic [N_SLOTS-1:0]   slot_busy,
    input  logic                 fire_ready,
    output logic                 fire_valid,
    output logic [ID_W-1:0]      fire_id,
    output logic [SLOT_W-1:0]    fire_slot,
    output logic [7:0]           shot_count
);

    localparam int              CNT_W     = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(COOLDOWN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [ID_W:0]   N_EXT     = (ID_W + 1)'(N_ENEMIES);
    localparam logic [ID_W-1:0] N_LOW     = ID_W'(N_ENEMIES);
    localparam logic [15:0]     LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        S_COOL  = 2'd0,
        S_PICK  = 2'd1,
        S_SCAN  = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic                fire_valid_q, fire_valid_d;
    logic [ID_W-1:0]     fire_id_q, fire_id_d;
    logic [SLOT_W-1:0]   fire_slot_q, fire_slot_d;
    logic [7:0]          shot_cnt_q, shot_cnt_d;

    logic [ID_W-1:0]     cand_raw, cand;
    logic [SLOT_W-1:0]   free_slot;
    logic                any_free;

`ifdef ENEMY_FIRE_SCAN_EN
    localparam logic [ID_W-1:0] ID_LAST  = ID_W'(N_ENEMIES - 1);
    localparam logic [ID_W-1:0] ID_ONE   = ID_W'(1);
    localparam logic [ID_W:0]   SCAN_ONE = (ID_W + 1)'(1);

    logic [ID_W-1:0] scan_idx_q, scan_idx_d;
    logic [ID_W:0]   scan_left_q, scan_left_d;   // indices still to test

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] i);
        return (i == ID_LAST) ? '0 : i + ID_ONE;
    endfunction
`endif

    // Galois LFSR, free running in every state.
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

    // Low bits of the LFSR can exceed the enemy count (but stay below twice
    // it), so one conditional subtraction folds them back into range.
    always_comb begin
        cand_raw = lfsr_q[ID_W-1:0];
        cand     = ({1'b0, cand_raw} >= N_EXT) ? cand_raw - N_LOW : cand_raw;
    end

    // Lowest-index free slot: scan downwards so the lowest hit wins.
    always_comb begin
        free_slot = '0;
        for (int s = N_SLOTS - 1; s >= 0; s--) begin
            if (!slot_busy[s]) free_slot = SLOT_W'(s);
        end
        any_free = ~&slot_busy;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fire_valid_d = fire_valid_q;
        fire_id_d    = fire_id_q;
        fire_slot_d  = fire_slot_q;
        shot_cnt_d   = shot_cnt_q;
`ifdef ENEMY_FIRE_SCAN_EN
        scan_idx_d   = scan_idx_q;
        scan_left_d  = scan_left_q;
`endif
        case (state_q)
            S_COOL: begin
                if (enable) begin
                    if (cnt_q == '0) state_d = S_PICK;
                    else             cnt_d   = cnt_q - CNT_ONE;
                end
            end
            S_PICK: begin
                if (!enable || (enemy_vivos == '0)) begin
                    state_d = S_COOL;
                    cnt_d   = CNT_INIT;
                end else if (any_free) begin
                    // With every slot busy we stay here and retry next cycle.
                    fire_slot_d = free_slot;
                    if (enemy_vivos[cand]) begin
                        fire_id_d    = cand;
                        fire_valid_d = 1'b1;
                        state_d      = S_ISSUE;
                    end else begin
`ifdef ENEMY_FIRE_SCAN_EN
                        state_d     = S_SCAN;
                        scan_idx_d  = next_id(cand);
                        scan_left_d = N_EXT;
`endif
                    end
                end
            end
            S_SCAN: begin
`ifdef ENEMY_FIRE_SCAN_EN
                if (!enable) begin
                    state_d = S_COOL;
                    cnt_d   = CNT_INIT;
                end else if (enemy_vivos[scan_idx_q]) begin
                    fire_id_d    = scan_idx_q;
                    fire_valid_d = 1'b1;
                    state_d      = S_ISSUE;
                end else if (scan_left_q == SCAN_ONE) begin
                    // Whole ring tested without a hit (enemies died mid-scan).
                    state_d = S_COOL;
                    cnt_d   = CNT_INIT;
                end else begin
                    scan_idx_d  = next_id(scan_idx_q);
                    scan_left_d = scan_left_q - SCAN_ONE;
                end
`else
                state_d = S_COOL;
                cnt_d   = CNT_INIT;
`endif
            end
            S_ISSUE: begin
                // Neither enable nor the alive mask can retract a pending shot.
                if (fire_ready) begin
                    fire_valid_d = 1'b0;
                    if (shot_cnt_q != 8'hFF) shot_cnt_d = shot_cnt_q + 8'd1;
                    state_d = S_COOL;
                    cnt_d   = CNT_INIT;
                end
            end
            default: begin
                state_d = S_COOL;
                cnt_d   = CNT_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_COOL;
            cnt_q        <= CNT_INIT;
            lfsr_q       <= LFSR_SEED;
            fire_valid_q <= 1'b0;
            fire_id_q    <= '0;
            fire_slot_q  <= '0;
            shot_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lfsr_q       <= lfsr_d;
            fire_valid_q <= fire_valid_d;
            fire_id_q    <= fire_id_d;
            fire_slot_q  <= fire_slot_d;
            shot_cnt_q   <= shot_cnt_d;
        end
    end

`ifdef ENEMY_FIRE_SCAN_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_idx_q  <= '0;
            scan_left_q <= '0;
        end else begin
            scan_idx_q  <= scan_idx_d;
            scan_left_q <= scan_left_d;
        end
    end
`endif

    assign fire_valid = fire_valid_q;
    assign fire_id    = fire_id_q;
    assign fire_slot  = fire_slot_q;
    assign shot_count = shot_cnt_q;

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Bench for enemy_fire_scheduler (COOLDOWN = 4). A transaction-level model
// predicts each shot: the pick cycle follows from the number of enabled
// cooldown cycles, the shooter from the LFSR value at that cycle plus either a
// ring search (scan build) or per-cycle retries (default build).
module tb_enemy_fire_scheduler;

    localparam int          NE   = 24;
    localparam int          NS   = 3;
    localparam int          C    = 4;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [NE-1:0] MASK0 = 24'h8A4215;
    localparam logic [NE-1:0] ONLY17 = 24'h020000;

    localparam int P_COOL = 0, P_PICK = 1, P_WAIT = 2, P_ISSUE = 3;

    logic          clk = 1'b0;
    logic          rst_n, enable, rdy;
    logic [NE-1:0] viv;
    logic [NS-1:0] busy;
    logic          fire_valid;
    logic [4:0]    fire_id;
    logic [1:0]    fire_slot;
    logic [7:0]    shot_count;

    always #5 clk = ~clk;

    enemy_fire_scheduler #(
        .N_ENEMIES(NE), .N_SLOTS(NS), .COOLDOWN(C), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset(rst_n), .enable(enable), .enemy_vivos(viv),
        .slot_busy(busy), .fire_ready(rdy), .fire_valid(fire_valid),
        .fire_id(fire_id), .fire_slot(fire_slot), .shot_count(shot_count)
    );

    int          n_chk = 0, n_err = 0;
    int          cyc = 0;
    logic [15:0] ml;
    int          ph = P_COOL, cool_left = C, wait_left = 0;
    int          m_id = 0, m_slot = 0, m_count = 0, m_hs = 0;
    int          hs_slot = 0;
    int          last_rise = -1;
    logic        prev_fv = 1'b0;
    bit          spacing_en = 1'b0;
    int          rec_mode = 0, rec_idx = 0;
    int          rec_ids[$];

    function automatic logic [15:0] lstep(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    function automatic int cand_of(input logic [15:0] x);
        int c;
        c = int'(x[4:0]);
        if (c >= NE) c -= NE;
        return c;
    endfunction

    function automatic int low_free(input logic [NS-1:0] b);
        for (int s = 0; s < NS; s++) if (!b[s]) return s;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance the shot model by the current cycle, using the inputs driven now.
    task automatic model_update();
        int c;
        if (!rst_n) return;
        case (ph)
            P_COOL: if (enable) begin
                cool_left--;
                if (cool_left == 0) ph = P_PICK;
            end
            P_PICK: begin
                if (!enable || viv == '0) begin
                    ph = P_COOL; cool_left = C;
                end else if (&busy) begin
                    // stalled, retry next cycle
                end else begin
                    c = cand_of(ml);
                    if (viv[c]) begin
                        m_id = c; m_slot = low_free(busy); ph = P_ISSUE;
                    end else begin
`ifdef ENEMY_FIRE_SCAN_EN
                        for (int k = 1; k < NE; k++) begin
                            if (viv[(c + k) % NE]) begin
                                m_id = (c + k) % NE; wait_left = k; break;
                            end
                        end
                        m_slot = low_free(busy);
                        ph = P_WAIT;
`endif
                    end
                end
            end
            P_WAIT: begin
                wait_left--;
                if (wait_left == 0) ph = P_ISSUE;
            end
            default: if (rdy) begin
                if (rec_mode == 1) rec_ids.push_back(m_id);
                if (rec_mode == 2 && rec_idx < rec_ids.size()) begin
                    chk("repeat_id", 32'(fire_id), rec_ids[rec_idx]);
                    rec_idx++;
                end
                hs_slot = int'(fire_slot);
                m_count = (m_count < 255) ? m_count + 1 : 255;
                m_hs++;
                ph = P_COOL; cool_left = C;
            end
        endcase
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            ml = SEED; ph = P_COOL; cool_left = C; m_count = 0;
        end else begin
            ml = lstep(ml);
        end
        chk("valid", 32'(fire_valid), 32'(ph == P_ISSUE));
        chk("count", 32'(shot_count), m_count);
        if (ph == P_ISSUE) begin
            chk("id", 32'(fire_id), m_id);
            chk("slot", 32'(fire_slot), m_slot);
        end
        if (fire_valid === 1'b1 && !prev_fv) begin
            if (spacing_en && last_rise >= 0)
                chk("spacing", 32'((cyc - last_rise) >= C + 2), 1);
            last_rise = cyc;
        end
        prev_fv = (fire_valid === 1'b1);
    endtask

    task automatic wait_shots(input int n, input int limit);
        int target;
        target = m_hs + n;
        for (int i = 0; i < limit && m_hs < target; i++) step();
        chk("shot_timeout", 32'(m_hs >= target), 1);
    endtask

    task automatic wait_issue(input int limit);
        for (int i = 0; i < limit && ph != P_ISSUE; i++) step();
        chk("reach_issue", 32'(fire_valid), 1);
    endtask

    initial begin
        int base;
        // Reset, then record the first shooters from the seed.
        rst_n = 1'b0; enable = 1'b1; viv = MASK0; busy = '0; rdy = 1'b1;
        step();
        step();
        chk("rst_id", 32'(fire_id), 0);
        chk("rst_slot", 32'(fire_slot), 0);
        rst_n = 1'b1;
        rec_mode = 1;
        wait_shots(4, 600);
        rec_mode = 0;

        // Single living enemy 17, all slots free.
        viv = ONLY17;
        spacing_en = 1'b1;
        wait_shots(5, 2000);
        spacing_en = 1'b0;

        // Slots 0 and 1 busy.
        busy = 3'b011;
        wait_shots(1, 500);
        chk("slot_011", hs_slot, 2);

        // All slots busy for 10 cycles, then only slot 1 free.
        busy = 3'b111;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("busy_novalid", 32'(fire_valid), 0);
        end
        busy = 3'b101;
        wait_shots(1, 500);
        chk("slot_101", hs_slot, 1);

        // Back-pressure in ISSUE while the shooter dies and the game pauses.
        busy = '0; rdy = 1'b0;
        wait_issue(500);
        viv = '0; enable = 1'b0; base = m_count;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("hold_valid", 32'(fire_valid), 1);
        end
        rdy = 1'b1; enable = 1'b1; viv = ONLY17;
        step();
        chk("hold_count", 32'(shot_count), base + 1);

        // No living enemies for 50 cycles.
        viv = '0; base = m_count;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("dead_novalid", 32'(fire_valid), 0);
        end
        chk("dead_count", 32'(shot_count), base);
        viv = ONLY17;

        // Randomized traffic until the shot counter has saturated.
        for (int i = 0; i < 12000 && m_hs < 262; i++) begin
            if (ph == P_COOL) begin
                enable = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) begin
                    viv  = ($urandom_range(0, 15) == 0) ? '0 : NE'($urandom);
                    busy = NS'($urandom_range(0, 7));
                end
            end else begin
                enable = 1'b1;
            end
            if (ph == P_PICK && &busy) busy = NS'($urandom_range(0, 6));
            rdy = ($urandom_range(0, 3) != 0);
            step();
        end
        chk("sat_count", 32'(shot_count), 255);

        // Reset while a shot is pending with the counter saturated.
        rdy = 1'b0; enable = 1'b1; busy = '0; viv = ONLY17;
        wait_issue(2000);
        chk("pre_rst_sat", 32'(shot_count), 255);
        rst_n = 1'b0;
        step();
        chk("rst2_valid", 32'(fire_valid), 0);
        chk("rst2_id", 32'(fire_id), 0);
        chk("rst2_slot", 32'(fire_slot), 0);
        chk("rst2_count", 32'(shot_count), 0);

        // Same inputs from reset must replay the same shooters.
        rst_n = 1'b1; enable = 1'b1; viv = MASK0; busy = '0; rdy = 1'b1;
        rec_mode = 2; rec_idx = 0;
        wait_shots(4, 600);
        rec_mode = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/enemy_fire_scheduler.md
# enemy_fire_scheduler

- Decides which living enemy fires next and which free bullet slot carries the shot.
- Sits between the game engine (enemy alive mask, run/pause state) and the enemy bullet unit.
- Enforces a minimum cooldown between shots and hands each shot over through a valid/ready handshake.
- Random enemy choice uses an internal LFSR; a dead pick is resolved by a bounded circular scan.

## Interface
- `N_ENEMIES`, 24: number of enemies; width of the alive mask.
- `N_SLOTS`, 3: number of enemy bullet slots.
- `COOLDOWN`, 1000000: number of cycles spent in COOLDOWN before each pick; must be ≥1.
- `LFSR_SEED`, 16'hACE1: LFSR load value on reset; must be nonzero.
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous active-low reset; one clock; sampled on the rising edge of `clk`.
- `enable`, in, 1: game running (engine state 0); low pauses scheduling.
- `enemy_vivos`, in, N_ENEMIES: bit i = 1 means enemy i is alive.
- `slot_busy`, in, N_SLOTS: bit s = 1 means bullet slot s is in flight.
- `fire_ready`, in, 1: bullet unit accepts the shot.
- `fire_valid`, out, 1: shot request pending.
- `fire_id`, out, $clog2(N_ENEMIES): shooting enemy index.
- `fire_slot`, out, max(1,$clog2(N_SLOTS)): slot to launch in.
- `shot_count`, out, 8: accepted shots since reset, saturating at 255.

## Operation
- **LFSR**
  - 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - Advances every cycle regardless of state.
  - Candidate `c` = low W bits of the LFSR (W = width of `fire_id`); if `c` ≥ N_ENEMIES, use `c` − N_ENEMIES.
- **COOLDOWN**
  - On entry, the counter loads COOLDOWN−1.
  - It decrements once per cycle while `enable`=1 and holds while `enable`=0.
  - When counter = 0 and `enable`=1, go to PICK.
- **PICK** (one cycle per attempt)
  - If `enemy_vivos`=0: go to COOLDOWN.
  - Else if all `slot_busy`=1: stay in PICK and retry next cycle with no reload.
  - Else latch `fire_slot` = lowest-index free slot.
    - If `enemy_vivos[c]`=1: latch `fire_id`=c and go to ISSUE.
    - Otherwise go to SCAN with index c+1 (wrapping at N_ENEMIES).
- **SCAN**
  - Tests one index per cycle; on the first alive index, latch `fire_id` and go to ISSUE.
  - Index wraps from N_ENEMIES−1 to 0.
  - After N_ENEMIES tested indices with no alive enemy, go to COOLDOWN.
- **ISSUE**
  - `fire_valid`=1; `fire_id` and `fire_slot` are held stable.
  - On `fire_valid` & `fire_ready`: increment `shot_count` (saturating) and go to COOLDOWN.
- **enable low**
  - In PICK or SCAN: abort to COOLDOWN.
  - In ISSUE: no effect. Once `fire_valid` is raised it stays high until the handshake, even if the chosen enemy dies or `enable` falls.
- **Reset**
  - State COOLDOWN with counter = COOLDOWN−1; LFSR = LFSR_SEED.
  - `fire_valid`=0, `fire_id`=0, `fire_slot`=0, `shot_count`=0.
  - Reset mid-ISSUE drops `fire_valid` on the next edge; no shot is counted.

## Timing
- All outputs are registered.
- With `enable`=1 and `fire_ready`=1, shots are exactly COOLDOWN+2 cycles apart if the candidate is alive: COOLDOWN cycles, 1 PICK cycle, 1 ISSUE cycle.
- A SCAN path adds k cycles, where k = number of indices tested before the hit, 1 ≤ k ≤ N_ENEMIES−1.
- `fire_valid` rises on the edge leaving PICK/SCAN and falls on the edge after the handshake.
- Inputs are sampled at the cycle of use, with no pre-latching: `enemy_vivos`, `slot_busy`, `enable`.
- Simultaneous death of the candidate in the PICK cycle: the sampled value decides.

## Configuration
- `ENEMY_FIRE_SCAN_EN` defined: SCAN state is present, as described above.
- `ENEMY_FIRE_SCAN_EN` undefined:
  - SCAN is removed. A dead candidate in PICK stays in PICK and retries next cycle with a fresh LFSR candidate.
  - When `enemy_vivos`=0, PICK still returns to COOLDOWN.

## Test plan
- Default macro set, COOLDOWN=4, `enable`=1, `fire_ready`=1, `enemy_vivos`=only bit 17, `slot_busy`=3'b000:
  - every shot has `fire_id`=17 and `fire_slot`=0;
  - successive `fire_valid` pulses are ≥6 cycles apart;
  - `shot_count` increments by 1 per pulse.
- `slot_busy`=3'b011 → `fire_slot`=2.
- `slot_busy`=3'b111 for 10 cycles, then 3'b101:
  - no `fire_valid` while all slots are busy;
  - next shot has `fire_slot`=1.
- `fire_ready`=0 for 8 cycles in ISSUE, with `enemy_vivos` cleared and `enable`=0 during the wait → `fire_valid`, `fire_id` and `fire_slot` are held stable; one shot is counted when `fire_ready`=1.
- `enemy_vivos`=0 for 50 cycles → `fire_valid` never asserts and `shot_count` stays unchanged.
- Drive `reset`=0 for one cycle while `fire_valid`=1 with `shot_count`=255 (saturated, after >255 shots) → all outputs return to 0 on the next edge.
- The first shot after reset repeats the same `fire_id` sequence as the first run, because the LFSR is deterministic.
